irq_controller: RTL
===================

Name: irq_controller

Overview:
- Memory-mapped priority interrupt controller between the peripheral interrupt outputs (VIA, UART, future sources) and the single active-high CPU IRQ input.
- Replaces the bare OR of the active-low peripheral IRQ lines.
- Per-source synchronisation, edge/level capture, masking, a global enable and a priority vector register for the ISR.
- Sits on the CPU bus at its own 16-byte decode window; only register select bits rs[1:0] are used.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8). Register bits at index NUM_SRC and above read 0 and ignore writes.

Ports:
- clk  input  1  CPU-domain clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cs  input  1  chip select from address decode
- rw  input  1  1 = read, 0 = write (CPU WE inverted)
- rs  input  2  register select (address[1:0])
- data_in  input  8  CPU write data
- data_out  output  8  register read data, combinational from cs/rs
- irq_n_in  input  NUM_SRC  active-low source requests, may be asynchronous to clk
- irq  output  1  registered, active-high CPU interrupt request

Behaviour:
- Reset: all sync flops = 1 (inactive); PEND, MASK, MODE, GIE = 0; irq = 0. data_out reads 0x00 for every register.
- Synchroniser: 2-flop chain per source gives s[i].
- Edge mode: a falling edge of s[i] is detected against a third flop holding the previous s[i].
- Pending register PEND[i], updated every clk:
  - MODE[i] = 0 (level): PEND[i] <= ~s[i].
  - MODE[i] = 1 (edge): PEND[i] <= (PEND[i] & ~clr[i]) | fall[i]. clr is a write-1 to STATUS that cycle.
  - Simultaneous fall and clear on the same bit: set wins, bit stays 1.
  - Writes to STATUS have no effect on level-mode bits.
- ACT = PEND & MASK. The irq register loads GIE & |ACT each clk.
- Latency: with GIE = 1 and MASK = 1, irq goes high on the 4th rising edge counted from the first edge that samples irq_n_in low (sync1, sync2, PEND, irq).
- Deassert latency is the same in level mode. In edge mode irq falls 2 edges after the clearing write (PEND, then irq).
- Register map, read via data_out while cs = 1; reads are side-effect free. When cs = 0, data_out = 0x00.
  - 0 STATUS: read ACT. Write: W1C edge-mode PEND bits.
  - 1 MASK: R/W, 1 = source enabled.
  - 2 MODE: R/W, 1 = falling-edge latched, 0 = level.
  - 3 VECTOR/CTRL:
    - Read = {any, 4'b0, idx[2:0]}. any = |ACT. idx = lowest-numbered set bit of ACT (bit 0 highest priority). Reads 0x00 when nothing is active.
    - Write: bit0 = GIE; other bits ignored.
    - The GIE value is readable only indirectly, via irq.
- Writes take effect on the rising edge where cs & ~rw.
- MODE change 0->1 for a bit: PEND[i] cleared on that edge, so a stale level does not become a latched edge.
- MODE change 1->0: PEND[i] reloads from ~s[i] on the next edge.
- Masking a pending bit does not clear PEND; unmasking later re-raises irq.
- GIE = 0 suppresses irq only; PEND keeps capturing.
- Asynchronous rst mid-operation forces every register above to its reset value immediately. Edges occurring while rst is high are discarded.

Test Plan:
- Reset/defaults: assert rst mid-run with sources low -> irq = 0 immediately; all four registers read 0x00 after release.
- Level source: MASK = 0x02, GIE = 1, drive irq_n_in[1] low at edge 0 -> irq = 1 at edge 4, VECTOR = 0x81, STATUS = 0x02. Release -> irq = 0 four edges later.
- Priority: MASK = 0xFF, GIE = 1, sources 5 and 2 low together -> VECTOR = 0x82. Release source 2 -> VECTOR = 0x85.
- Edge latch and W1C: MODE = 0x01, MASK = 0x01, GIE = 1, 1-cycle low pulse on source 0 -> STATUS = 0x01 held after pulse ends. Write 0x01 to STATUS -> irq = 0 two edges later. Writing 0x01 while a new falling edge arrives the same cycle -> STATUS stays 0x01.
- Mask/GIE gating: pending source with MASK bit 0 -> irq = 0, STATUS = 0x00. Set MASK -> irq rises in 2 edges. Then GIE = 0 -> irq = 0 while STATUS stays nonzero.
- MODE switch: source 3 held low in level mode (PEND = 1), write MODE = 0x08 -> PEND[3] = 0 and stays 0 until a new falling edge.

Source files
------------

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Memory-mapped priority interrupt controller with per-source sync,
//            level/edge capture, masking, global enable and vector readout.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               rw,
    input  logic [1:0]         rs,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic [NUM_SRC-1:0] irq_n_in,
    output logic               irq
);

    localparam logic [7:0] c_SRC_MASK   = 8'((9'd1 << NUM_SRC) - 9'd1);
    localparam logic [1:0] c_REG_STATUS = 2'd0;
    localparam logic [1:0] c_REG_MASK   = 2'd1;
    localparam logic [1:0] c_REG_MODE   = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;

    logic [7:0] w_src_n;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_prev;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic [7:0] r_mode;
    logic       r_gie;
    logic       r_irq;

    logic       w_wr;
    logic       w_wr_status;
    logic       w_wr_mask;
    logic       w_wr_mode;
    logic       w_wr_ctrl;
    logic [7:0] w_fall;
    logic [7:0] w_clr;
    logic [7:0] w_mode_rise;
    logic [7:0] w_pend_next;
    logic [7:0] w_act;
    logic [2:0] w_idx;

    // Unimplemented source slots are tied inactive so every register is 8 bits.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_src
            if (i < NUM_SRC) begin : g_used
                assign w_src_n[i] = irq_n_in[i];
            end else begin : g_unused
                assign w_src_n[i] = 1'b1;
            end
        end
    endgenerate

    assign w_wr        = cs & ~rw;
    assign w_wr_status = w_wr & (rs == c_REG_STATUS);
    assign w_wr_mask   = w_wr & (rs == c_REG_MASK);
    assign w_wr_mode   = w_wr & (rs == c_REG_MODE);
    assign w_wr_ctrl   = w_wr & (rs == c_REG_CTRL);

    assign w_fall      = r_prev & ~r_sync2;
    assign w_clr       = {8{w_wr_status}} & data_in & r_mode;
    assign w_mode_rise = {8{w_wr_mode}} & data_in & c_SRC_MASK & ~r_mode;
    assign w_act       = r_pend & r_mask;

    // Entering edge mode drops any stale level so it is not mistaken for an edge;
    // a capture in the same cycle as a W1C clear takes precedence.
    always_comb begin
        w_pend_next = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_mode_rise[i])
                w_pend_next[i] = 1'b0;
            else if (!r_mode[i])
                w_pend_next[i] = ~r_sync2[i];
            else
                w_pend_next[i] = (r_pend[i] & ~w_clr[i]) | w_fall[i];
        end
    end

    // Bit 0 has highest priority, so scan downward and let the lowest set bit win.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_act[i])
                w_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
            r_prev  <= 8'hFF;
            r_pend  <= 8'h00;
            r_mask  <= 8'h00;
            r_mode  <= 8'h00;
            r_gie   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_sync1 <= w_src_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= w_pend_next;
            r_irq   <= r_gie & (|w_act);
            if (w_wr_mask)
                r_mask <= data_in & c_SRC_MASK;
            if (w_wr_mode)
                r_mode <= data_in & c_SRC_MASK;
            if (w_wr_ctrl)
                r_gie <= data_in[0];
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (cs) begin
            case (rs)
                c_REG_STATUS: data_out = w_act;
                c_REG_MASK:   data_out = r_mask;
                c_REG_MODE:   data_out = r_mode;
                default:      data_out = (|w_act) ? {1'b1, 4'b0000, w_idx} : 8'h00;
            endcase
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
